seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver; successor to the static single-digit driver.
- Drives NUM_DIGITS common-anode digits from one shared segment bus, CA..CG plus DP.
- Latches a hex value, per-digit decimal points and per-digit blank flags on a load strobe, then scans digits round-robin.
- Inserts a ghosting dead-time at the start of each digit slot.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off (0 allowed).
- ACTIVE_LOW, 1, 1: anodes, segments and DP are active-low (board default); 0: active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  when 1, capture value/dp_in/blank_in into shadow registers at this edge.
- value  input  4*NUM_DIGITS  hex nibble per digit; digit i = value[4i+3:4i], digit 0 rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit (1 = lit).
- blank_in  input  NUM_DIGITS  1 = digit i is dark for its whole slot.
- an  output  NUM_DIGITS  anode enables; an[i] drives AN(i).
- seg  output  7  seg[0]=CA, seg[1]=CB, ... seg[6]=CG.
- dp  output  1  decimal point (DP).
- digit_idx  output  3  index of the digit currently driven, for debug and verification.

Behaviour:
- Definitions: OFF = 1 if ACTIVE_LOW else 0; ON = ~OFF.
- Reset (synchronous, highest priority, mid-scan included):
  - div_cnt=0, idx=0, all shadow registers 0.
  - an=all OFF, seg=all OFF, dp=OFF, digit_idx=0.
- Shadow load: on an edge with load=1 and reset=0, shadow_value, shadow_dp and shadow_blank take the inputs. Outputs reflect the change one cycle later (registered-output latency). With load=0, shadows hold. Inputs are never decoded directly (no tearing).
- Scan counter:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At div_cnt=REFRESH_DIV-1: div_cnt->0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - NUM_DIGITS=1: idx stays 0.
- Registered outputs, each edge (one-cycle latency from div_cnt/idx):
  - digit_idx <= idx.
  - an[idx] <= ON iff div_cnt >= BLANK_CYCLES and shadow_blank[idx]=0; all other an bits OFF. At most one anode is ever ON.
  - seg <= decoded shadow nibble of digit idx, inverted if ACTIVE_LOW.
  - dp <= shadow_dp[idx] ? ON : OFF.
  - seg and dp are driven even during dead-time and blank slots; darkness comes from the anodes.
- Decode table, active-high, listed as CA..CG:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1111011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
- Simultaneous load and slot wrap: both take effect; the new slot shows the new shadow data one cycle later.
- Full-frame period = NUM_DIGITS*REFRESH_DIV cycles.

Test Plan:
- Reset: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; hold reset 3 cycles -> an=4'b1111, seg=7'b1111111, dp=1, digit_idx=0; all stay off 2 cycles after release (dead-time).
- Static zero: load value=16'h0000, dp_in=0, blank_in=0 -> in every slot, after dead-time, seg=7'b1000000 (CG=1 only) and dp=1; an walks 1110,1101,1011,0111, each ON for 6 cycles per 8-cycle slot.
- Hex decode: load value=16'hA5F3, dp_in=4'b0100 -> digit0 seg=7'b0110000 (3), digit1 seg=7'b0001110 (F), digit2 seg=7'b0010010 (5) with dp=0, digit3 seg=7'b0001000 (A).
- Blanking and wrap: blank_in=4'b1010 -> an stays 1111 during slots 1 and 3; digit_idx sequence 0,1,2,3,0 with wrap exactly every 8 cycles.
- Load coherence: change value with load=0 mid-frame -> display unchanged; pulse load during the last cycle of slot 2 -> slot 3 shows the new nibble.
- Reset mid-scan: assert reset while digit_idx=2 and an=1011 -> next edge an=1111, digit_idx=0, shadows cleared; after release digit 0 shows 0 after 2 dead cycles. Rerun with ACTIVE_LOW=0 -> all output polarities inverted.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow-latched hex digits scanned
// round-robin over a shared segment bus, with per-slot anode dead-time.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [2:0]              digit_idx
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic              OFF      = (ACTIVE_LOW != 0);
  localparam logic              ON       = ~OFF;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt;
  logic [2:0]              idx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    slot_live;
  logic [NUM_DIGITS-1:0]   an_d;

  // Active-high segment pattern, bit 0 = CA ... bit 6 = CG.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] s);
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  // Scan state and shadow registers; the display only ever decodes shadows.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        sel_nib   = shadow_value[4*i +: 4];
        sel_dp    = shadow_dp[i];
        sel_blank = shadow_blank[i];
      end
    end
    slot_live = (int'(div_cnt) >= BLANK_CYCLES) && !sel_blank;
    an_d = {NUM_DIGITS{OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i) && slot_live) an_d[i] = ON;
    end
  end

  // Output register stage: one cycle behind div_cnt/idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      an        <= {NUM_DIGITS{OFF}};
      seg       <= {7{OFF}};
      dp        <= OFF;
      digit_idx <= '0;
    end else begin
      an        <= an_d;
      seg       <= seg_polarity(hex_decode(sel_nib));
      dp        <= sel_dp ? ON : OFF;
      digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: active-low and active-high
// instances share stimulus; outputs are checked every cycle and at key points.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;

  logic [3:0] an_l, an_h;
  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h;
  logic [2:0] idx_l, idx_h;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) u_al (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an_l), .seg(seg_l), .dp(dp_l), .digit_idx(idx_l)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)
  ) u_ah (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an_h), .seg(seg_h), .dp(dp_h), .digit_idx(idx_h)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: cycles since reset release plus the expected shadows.
  int          c = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0, m_bl = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [2:0]  e_idx;

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int slot, pos;
    logic [3:0] inv_an;
    logic [6:0] inv_seg;
    logic       inv_dp;
    @(posedge clk);
    if (reset) begin
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_idx = '0;
      c = 0; m_val = '0; m_dp = '0; m_bl = '0;
    end else begin
      slot  = (c / 8) % 4;
      pos   = c % 8;
      e_idx = 3'(slot);
      e_seg = dec[m_val[slot*4 +: 4]];
      e_dp  = m_dp[slot];
      e_an  = (pos >= 2 && !m_bl[slot]) ? 4'(1 << slot) : 4'h0;
      if (load) begin
        m_val = value; m_dp = dp_in; m_bl = blank_in;
      end
      c++;
    end
    #1;
    inv_an = ~e_an; inv_seg = ~e_seg; inv_dp = ~e_dp;
    chk("an_al",  an_l,  inv_an);
    chk("seg_al", seg_l, inv_seg);
    chk("dp_al",  dp_l,  inv_dp);
    chk("idx_al", idx_l, e_idx);
    chk("an_ah",  an_h,  e_an);
    chk("seg_ah", seg_h, e_seg);
    chk("dp_ah",  dp_h,  e_dp);
    chk("idx_ah", idx_h, e_idx);
  endtask

  task automatic wait_lit(input logic [2:0] k, input logic [3:0] an_exp);
    int n = 0;
    while (!(idx_l === k && an_l === an_exp) && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    assert (n < 40) else begin
      miscompares++;
      $error("FAIL wait_slot%0d: observed timeout expected an=%b", k, an_exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    repeat (3) tick();
    chk("rst_an_al",  an_l,  4'b1111);
    chk("rst_seg_al", seg_l, 7'b1111111);
    chk("rst_dp_al",  dp_l,  1'b1);
    chk("rst_idx",    idx_l, 3'd0);
    chk("rst_an_ah",  an_h,  4'b0000);
    chk("rst_seg_ah", seg_h, 7'b0000000);

    reset = 1'b0;
    tick(); tick();
    chk("dead_an", an_l, 4'b1111);
    tick();
    chk("first_on",  an_l,  4'b1110);
    chk("zero_seg",  seg_l, 7'b1000000);
    chk("zero_dp",   dp_l,  1'b1);

    // static zero, full frame and beyond
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (34) tick();
    wait_lit(3'd3, 4'b0111);
    chk("zero_d3", seg_l, 7'b1000000);

    // hex decode
    value = 16'hA5F3; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0; dp_in = 4'b0000;
    wait_lit(3'd0, 4'b1110);
    chk("hex_d0",    seg_l, 7'b0110000);
    chk("hex_d0_ah", seg_h, 7'b1001111);
    chk("hex_d0_dp", dp_l,  1'b1);
    wait_lit(3'd1, 4'b1101);
    chk("hex_d1", seg_l, 7'b0001110);
    wait_lit(3'd2, 4'b1011);
    chk("hex_d2",    seg_l, 7'b0010010);
    chk("hex_d2_dp", dp_l,  1'b0);
    wait_lit(3'd3, 4'b0111);
    chk("hex_d3", seg_l, 7'b0001000);

    // blanking of digits 1 and 3
    blank_in = 4'b1010; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (40) tick();

    // unloaded input changes must not reach the display
    value = 16'h1234;
    repeat (16) tick();

    // load on the last cycle of slot 2
    while ((c % 32) != 23) tick();
    value = 16'hE234; blank_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    wait_lit(3'd3, 4'b0111);
    chk("coh_d3",    seg_l, 7'b0000110);
    chk("coh_d3_ah", seg_h, 7'b1111001);

    // reset in the middle of slot 2
    wait_lit(3'd2, 4'b1011);
    reset = 1'b1;
    tick();
    chk("mid_an_al",  an_l,  4'b1111);
    chk("mid_idx",    idx_l, 3'd0);
    chk("mid_an_ah",  an_h,  4'b0000);
    reset = 1'b0;
    tick(); tick();
    chk("mid_dead", an_l, 4'b1111);
    tick();
    chk("mid_on_al",  an_l,  4'b1110);
    chk("mid_seg_al", seg_l, 7'b1000000);
    chk("mid_on_ah",  an_h,  4'b0001);
    chk("mid_seg_ah", seg_h, 7'b0111111);
    chk("mid_dp_al",  dp_l,  1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
